// File: rtl/sccb_init_ctrl.sv
// Camera configuration sequencer: sensor power-up, then one SCCB 3-phase write per table entry.
// init_done is a stable level once the end-of-table marker has been decoded.
module sccb_init_ctrl #(
  parameter int unsigned QDIV      = 125,
  parameter int unsigned PWRUP_CYC = 1_000_000,
  parameter int unsigned DELAY_CYC = 500_000,
  parameter logic [7:0]  DEV_ID    = 8'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reinit,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        cmos_rst_n,
  output logic        cmos_pwdn,
  output logic        busy,
  output logic        init_done,
  output logic [7:0]  nack_cnt
);

  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int CMAX = (PWRUP_CYC > DELAY_CYC) ? PWRUP_CYC : DELAY_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [QW-1:0] Q_LAST   = QW'(QDIV - 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] DL_LAST  = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RST_HALF = CW'(PWRUP_CYC / 2);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BYTE  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DELAY = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]    state, state_nx;
  logic [QW-1:0] qcnt, qcnt_nx;
  logic [2:0]    quarter, quarter_nx;
  logic [3:0]    bit_cnt, bit_nx;
  logic [1:0]    byte_cnt, byte_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic          fetch_cnt, fetch_nx;
  logic [7:0]    addr_nx;
  logic [7:0]    sub, dat, cur_byte;
  logic          sioc_nx, oe_nx;
  logic          q_end, ack_sample, entry_write;

  assign q_end       = (qcnt == Q_LAST);
  assign ack_sample  = (state == S_BYTE) && (bit_cnt == 4'd8) && (quarter == 3'd2) && q_end;
  assign entry_write = (state == S_FETCH) && fetch_cnt &&
                       (rom_data != 16'hFFFF) && (rom_data != 16'hFFF0);
  assign cmos_pwdn   = 1'b0;

  always_comb begin
    state_nx   = state;
    qcnt_nx    = '0;
    quarter_nx = quarter;
    bit_nx     = bit_cnt;
    byte_nx    = byte_cnt;
    cyc_nx     = cyc;
    fetch_nx   = 1'b0;
    addr_nx    = rom_addr;
    case (state)
      S_PWRUP: begin
        if (cyc == PW_LAST) begin
          state_nx = S_FETCH;
          cyc_nx   = '0;
        end else begin
          cyc_nx = cyc + 1'b1;
        end
      end
      // first cycle lets the address settle, second sees the registered table word
      S_FETCH: begin
        if (!fetch_cnt) begin
          fetch_nx = 1'b1;
        end else if (rom_data == 16'hFFFF) begin
          state_nx = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          state_nx = S_DELAY;
          cyc_nx   = '0;
        end else begin
          state_nx   = S_START;
          quarter_nx = '0;
        end
      end
      S_START, S_BYTE, S_STOP, S_GAP: begin
        qcnt_nx = q_end ? '0 : qcnt + 1'b1;
        if (q_end) begin
          quarter_nx = quarter + 1'b1;
          case (state)
            S_START: begin
              if (quarter == 3'd3) begin
                state_nx   = S_BYTE;
                quarter_nx = '0;
                bit_nx     = '0;
                byte_nx    = '0;
              end
            end
            S_BYTE: begin
              if (quarter == 3'd3) begin
                quarter_nx = '0;
                if (bit_cnt == 4'd8) begin
                  bit_nx = '0;
                  if (byte_cnt == 2'd2) state_nx = S_STOP;
                  else                  byte_nx  = byte_cnt + 1'b1;
                end else begin
                  bit_nx = bit_cnt + 1'b1;
                end
              end
            end
            S_STOP: begin
              if (quarter == 3'd3) begin
                state_nx   = S_GAP;
                quarter_nx = '0;
              end
            end
            default: begin
              if (quarter == 3'd7) begin
                state_nx   = S_FETCH;
                quarter_nx = '0;
                addr_nx    = rom_addr + 1'b1;
              end
            end
          endcase
        end
      end
      S_DELAY: begin
        if (cyc == DL_LAST) begin
          state_nx = S_FETCH;
          addr_nx  = rom_addr + 1'b1;
        end else begin
          cyc_nx = cyc + 1'b1;
        end
      end
      S_DONE: begin
        if (reinit) begin
          state_nx = S_PWRUP;
          addr_nx  = '0;
          cyc_nx   = '0;
        end
      end
      default: state_nx = S_PWRUP;
    endcase
  end

  // Bus levels are decoded from the next position so the registered pins line up with it.
  always_comb begin
    sioc_nx  = 1'b1;
    oe_nx    = 1'b0;
    cur_byte = DEV_ID;
    case (byte_nx)
      2'd1:    cur_byte = sub;
      2'd2:    cur_byte = dat;
      default: cur_byte = DEV_ID;
    endcase
    case (state_nx)
      S_START: begin
        sioc_nx = (quarter_nx != 3'd3);
        oe_nx   = quarter_nx[1];
      end
      S_BYTE: begin
        sioc_nx = quarter_nx[1];
        oe_nx   = (bit_nx == 4'd8) ? 1'b0 : ~cur_byte[~bit_nx[2:0]];
      end
      S_STOP: begin
        sioc_nx = (quarter_nx != 3'd0);
        oe_nx   = ~quarter_nx[1];
      end
      default: begin
        sioc_nx = 1'b1;
        oe_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      qcnt       <= '0;
      quarter    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      cyc        <= '0;
      fetch_cnt  <= 1'b0;
      rom_addr   <= '0;
      sub        <= '0;
      dat        <= '0;
      sioc       <= 1'b1;
      siod_oe    <= 1'b0;
      cmos_rst_n <= 1'b0;
      busy       <= 1'b1;
      init_done  <= 1'b0;
      nack_cnt   <= '0;
    end else begin
      state      <= state_nx;
      qcnt       <= qcnt_nx;
      quarter    <= quarter_nx;
      bit_cnt    <= bit_nx;
      byte_cnt   <= byte_nx;
      cyc        <= cyc_nx;
      fetch_cnt  <= fetch_nx;
      rom_addr   <= addr_nx;
      sioc       <= sioc_nx;
      siod_oe    <= oe_nx;
      cmos_rst_n <= (state_nx != S_PWRUP) || (cyc_nx >= RST_HALF);
      busy       <= (state_nx != S_DONE);
      init_done  <= (state_nx == S_DONE);
      if (entry_write) begin
        sub <= rom_data[15:8];
        dat <= rom_data[7:0];
      end
      if ((state == S_DONE) && reinit)
        nack_cnt <= '0;
      else if (ack_sample && siod_in && (nack_cnt != 8'hFF))
        nack_cnt <= nack_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sccb_init_ctrl.sv
// Directed bench for sccb_init_ctrl with short timing parameters, a registered table ROM
// and an SCCB slave that decodes START/STOP/bytes and optionally acknowledges.
module tb_sccb_init_ctrl;

  localparam int QDIV      = 2;
  localparam int PWRUP_CYC = 20;
  localparam int DELAY_CYC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_oe, siod_in;
  logic        cmos_rst_n, cmos_pwdn, busy, init_done;
  logic [7:0]  nack_cnt;

  sccb_init_ctrl #(
    .QDIV(QDIV), .PWRUP_CYC(PWRUP_CYC), .DELAY_CYC(DELAY_CYC), .DEV_ID(8'h42)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .rom_addr(rom_addr), .rom_data(rom_data),
    .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in), .cmos_rst_n(cmos_rst_n),
    .cmos_pwdn(cmos_pwdn), .busy(busy), .init_done(init_done), .nack_cnt(nack_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic       ack_en = 1'b1;
  logic       ack_pull = 1'b0;
  logic       dec_clr = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, sda_s;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx [0:15];
  int         start_cyc [0:3];
  int         bitn = 0, byte_n = 0, start_n = 0, stop_n = 0;

  assign siod_in = ~siod_oe & ~ack_pull;

  // Slave: SIOD edges while SIOC stays high are START/STOP; bits are taken on SIOC rising.
  always @(negedge clk) begin
    sda_s = siod_in;
    if (dec_clr) begin
      in_frame = 1'b0; ack_pull = 1'b0;
      bitn = 0; byte_n = 0; start_n = 0; stop_n = 0;
    end else if (prev_scl && sioc) begin
      if (prev_sda && !sda_s) begin
        in_frame = 1'b1; bitn = 0;
        if (start_n < 4) start_cyc[start_n] = cycle;
        start_n++;
      end else if (!prev_sda && sda_s) begin
        in_frame = 1'b0; stop_n++;
      end
    end else if (!prev_scl && sioc && in_frame) begin
      if (bitn < 8) begin
        shreg = {shreg[6:0], sda_s};
        bitn++;
      end else begin
        if (byte_n < 16) rx[byte_n] = shreg;
        byte_n++;
        bitn = 0;
      end
    end else if (prev_scl && !sioc && in_frame) begin
      ack_pull = ack_en && (bitn == 8);
    end
    prev_scl = sioc;
    prev_sda = sda_s;
  end

  int chk_n = 0, pass_n = 0, fail_n = 0;
  int c0 = 0, low_n = 0, idle_n = 0, addr_bad = 0, budget = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] t0, input logic [15:0] t1,
                               input logic [15:0] t2, input logic [15:0] t3, input logic ack);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = t0; rom[1] = t1; rom[2] = t2; rom[3] = t3;
    ack_en  = ack;
    dec_clr = 1'b1;
    tick();
    dec_clr = 1'b0;
  endtask

  task automatic pulseReinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    for (int i = 0; i < limit && !init_done; i++) tick();
    checkOutput(tag, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    applyStimulus(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    repeat (3) tick();
    checkOutput("rst_sioc", {31'd0, sioc}, 32'd1);
    checkOutput("rst_siod_oe", {31'd0, siod_oe}, 32'd0);
    checkOutput("rst_cmos_rst_n", {31'd0, cmos_rst_n}, 32'd0);
    checkOutput("rst_cmos_pwdn", {31'd0, cmos_pwdn}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_nack_cnt", {24'd0, nack_cnt}, 32'd0);
    checkOutput("rst_rom_addr", {24'd0, rom_addr}, 32'd0);

    $display("[TB] power-up");
    rst_n = 1'b1;
    c0 = cycle;
    for (int i = 0; i < PWRUP_CYC; i++) begin
      if (i > 0) tick();
      if (!cmos_rst_n) low_n++;
      if (sioc && !siod_oe) idle_n++;
      if (rom_addr != 8'd0) addr_bad++;
    end
    checkOutput("pwrup_rst_low_cycles", low_n, PWRUP_CYC / 2);
    checkOutput("pwrup_bus_idle_cycles", idle_n, PWRUP_CYC);
    checkOutput("pwrup_addr_nonzero", addr_bad, 0);
    checkOutput("pwrup_rst_high", {31'd0, cmos_rst_n}, 32'd1);

    // START at cycle 22 (after 20 PWRUP + 2 FETCH); its SIOD fall is 2 quarters in.
    $display("[TB] single write");
    waitDone("single_done", 1000);
    checkOutput("single_done_cycle", cycle - c0, 22 + 124 * QDIV + 2);
    checkOutput("single_start_cycle", start_cyc[0] - c0, 22 + 2 * QDIV);
    checkOutput("single_starts", start_n, 1);
    checkOutput("single_stops", stop_n, 1);
    checkOutput("single_bytes", byte_n, 3);
    checkOutput("single_data", {8'd0, rx[0], rx[1], rx[2]}, 32'h00421280);
    checkOutput("single_nack", {24'd0, nack_cnt}, 32'd0);
    checkOutput("single_addr", {24'd0, rom_addr}, 32'd1);
    repeat (5) tick();
    checkOutput("done_stable", {28'd0, init_done, busy, sioc, siod_oe}, 32'b1010);

    $display("[TB] nack");
    applyStimulus(16'h1280, 16'h1104, 16'hFFFF, 16'hFFFF, 1'b0);
    pulseReinit();
    checkOutput("reinit_state", {28'd0, init_done, busy, cmos_rst_n, 1'b0}, 32'b0100);
    checkOutput("reinit_addr", {24'd0, rom_addr}, 32'd0);
    waitDone("nack_done", 2000);
    checkOutput("nack_cnt", {24'd0, nack_cnt}, 32'd6);
    checkOutput("nack_bytes", byte_n, 6);
    checkOutput("nack_data_a", {rx[0], rx[1], rx[2], rx[3]}, 32'h42128042);
    checkOutput("nack_data_b", {16'd0, rx[4], rx[5]}, 32'h00001104);
    checkOutput("nack_stops", stop_n, 2);
    checkOutput("nack_start_spacing", start_cyc[1] - start_cyc[0], 124 * QDIV + 2);
    checkOutput("nack_addr", {24'd0, rom_addr}, 32'd2);

    $display("[TB] delay entry with reinit during a byte");
    applyStimulus(16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF, 1'b1);
    pulseReinit();
    budget = 0;
    while (byte_n < 1 && budget < 500) begin
      tick();
      budget++;
    end
    checkOutput("delay_first_byte_seen", {31'd0, byte_n >= 1}, 32'd1);
    pulseReinit();
    checkOutput("midbyte_reinit_ignored", {29'd0, busy, cmos_rst_n, init_done}, 32'b110);
    waitDone("delay_done", 2000);
    // a delay entry adds its own 2-cycle FETCH plus DELAY_CYC to the 124-quarter + FETCH spacing
    checkOutput("delay_start_spacing", start_cyc[1] - start_cyc[0], 124 * QDIV + 2 + 2 + DELAY_CYC);
    checkOutput("delay_bytes", byte_n, 6);
    checkOutput("delay_data_b", {16'd0, rx[4], rx[5]}, 32'h00001104);
    checkOutput("delay_nack_cleared", {24'd0, nack_cnt}, 32'd0);
    checkOutput("delay_addr", {24'd0, rom_addr}, 32'd3);

    $display("[TB] reset during sub-address");
    applyStimulus(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    pulseReinit();
    budget = 0;
    while (!(byte_n == 1 && bitn == 4 && !sioc) && budget < 1000) begin
      tick();
      budget++;
    end
    checkOutput("mid_reached", {31'd0, budget < 1000}, 32'd1);
    checkOutput("mid_nack_before", {24'd0, nack_cnt}, 32'd1);
    checkOutput("mid_bus_before", {30'd0, sioc, siod_oe}, 32'b01);
    rst_n   = 1'b0;
    dec_clr = 1'b1;
    #1;
    checkOutput("mid_bus_released", {30'd0, sioc, siod_oe}, 32'b10);
    checkOutput("mid_outputs_reset", {22'd0, nack_cnt, cmos_rst_n, busy}, 32'b01);
    ack_en = 1'b1;
    tick();
    dec_clr = 1'b0;
    rst_n   = 1'b1;
    waitDone("restart_done", 2000);
    checkOutput("restart_bytes", byte_n, 3);
    checkOutput("restart_data", {8'd0, rx[0], rx[1], rx[2]}, 32'h00421280);
    checkOutput("restart_nack", {24'd0, nack_cnt}, 32'd0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_n, chk_n);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
